// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared types, sizes and Johnson-code helpers for seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } seq_state_e;

  localparam int SEQ_W   = 4;
  localparam int SEQ_LEN = 8;

  function automatic logic [SEQ_W-1:0] johnson_nxt(input logic [SEQ_W-1:0] q);
    return {~q[0], q[SEQ_W-1:1]};
  endfunction

  // Walks the ring from 0000 so the legal set is defined by johnson_nxt alone.
  function automatic logic johnson_legal(input logic [SEQ_W-1:0] q);
    logic [SEQ_W-1:0] code;
    logic             hit;
    code = '0;
    hit  = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (q == code) hit = 1'b1;
      code = johnson_nxt(code);
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_checker_if
// Purpose  : Sample stream and status bundle between a source and seq_checker.
//            SEQ_CHECKER_CAPTURE_EN adds the first-mismatch capture signals.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_checker_if #(
  parameter int ERR_W = 8
);
  logic                     in_valid;
  logic [seq_pkg::SEQ_W-1:0] in_data;
  logic                     err_clr;
  logic                     locked;
  logic                     err_pulse;
  logic                     wrap_pulse;
  logic [ERR_W-1:0]         err_cnt;
`ifdef SEQ_CHECKER_CAPTURE_EN
  logic                     cap_valid;
  logic [seq_pkg::SEQ_W-1:0] cap_got;
  logic [seq_pkg::SEQ_W-1:0] cap_exp;

  modport master (
    output in_valid, in_data, err_clr,
    input  locked, err_pulse, wrap_pulse, err_cnt, cap_valid, cap_got, cap_exp
  );
  modport slave (
    input  in_valid, in_data, err_clr,
    output locked, err_pulse, wrap_pulse, err_cnt, cap_valid, cap_got, cap_exp
  );
`else
  modport master (
    output in_valid, in_data, err_clr,
    input  locked, err_pulse, wrap_pulse, err_cnt
  );
  modport slave (
    input  in_valid, in_data, err_clr,
    output locked, err_pulse, wrap_pulse, err_cnt
  );
`endif
endinterface
`default_nettype wire

// File: rtl/seq_chk_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_chk_cnt
// Purpose  : Saturating up-counter; clr zeroes the base, inc then adds one,
//            so clr+inc together loads 1.
// Revision : 1.0 - initial release
// ============================================================================
module seq_chk_cnt #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic [W-1:0]      cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (inc && (base != {W{1'b1}})) cnt_d = base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : seq_checker
// Purpose  : Self-synchronising checker for the 4-bit Johnson sequence with
//            lock, per-sample error, wrap pulse and saturating error count.
//            Define SEQ_CHECKER_CAPTURE_EN for first-mismatch capture outputs.
// Revision : 1.0 - initial release
// ============================================================================
module seq_checker
  import seq_pkg::*;
#(
  parameter int SYNC_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  seq_checker_if.slave bus
);

  localparam int RUN_W = 4;

  seq_state_e       state_q, state_d;
  logic [SEQ_W-1:0] exp_q, exp_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;

  logic [RUN_W-1:0] good_run, bad_run, good_next, bad_next;
  logic [ERR_W-1:0] err_cnt;
  logic             good_clr, good_inc, bad_clr, bad_inc, err_inc;
  logic             data_legal, data_match;

  assign data_legal = johnson_legal(bus.in_data);
  assign data_match = (bus.in_data == exp_q);
  assign good_next  = (good_run != '0 && data_match) ? good_run + 1'b1 : RUN_W'(1);
  assign bad_next   = bad_run + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      case (state_q)
        HUNT:    if (data_legal && good_next == RUN_W'(SYNC_CNT)) state_d = LOCKED;
        LOCKED:  if (!data_match && bad_next == RUN_W'(LOSS_CNT)) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    exp_d        = exp_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    good_clr     = 1'b0;
    good_inc     = 1'b0;
    bad_clr      = 1'b0;
    bad_inc      = 1'b0;
    err_inc      = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (!data_legal) begin
            good_clr = 1'b1;
          end else begin
            exp_d    = johnson_nxt(bus.in_data);
            good_inc = 1'b1;
            good_clr = !(good_run != '0 && data_match);
          end
          if (state_d == LOCKED) bad_clr = 1'b1;
        end
        LOCKED: begin
          // Flywheel: expected keeps advancing even through mismatches.
          exp_d = johnson_nxt(exp_q);
          if (data_match) begin
            bad_clr      = 1'b1;
            wrap_pulse_d = (bus.in_data == '0);
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            bad_inc     = 1'b1;
            if (state_d == HUNT) good_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q        <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      exp_q        <= exp_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  seq_chk_cnt #(.W(RUN_W)) u_good_run (
    .clk(clk), .rst(rst), .clr(good_clr), .inc(good_inc), .cnt(good_run)
  );

  seq_chk_cnt #(.W(RUN_W)) u_bad_run (
    .clk(clk), .rst(rst), .clr(bad_clr), .inc(bad_inc), .cnt(bad_run)
  );

  // Increment is masked by err_clr so a simultaneous clear leaves zero.
  seq_chk_cnt #(.W(ERR_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(bus.err_clr), .inc(err_inc && !bus.err_clr), .cnt(err_cnt)
  );

  assign bus.locked     = (state_q == LOCKED);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.err_cnt    = err_cnt;

`ifdef SEQ_CHECKER_CAPTURE_EN
  logic             cap_valid_q, cap_valid_d;
  logic [SEQ_W-1:0] cap_got_q, cap_got_d;
  logic [SEQ_W-1:0] cap_exp_q, cap_exp_d;

  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_got_d   = cap_got_q;
    cap_exp_d   = cap_exp_q;
    if (bus.err_clr) begin
      cap_valid_d = 1'b0;
      cap_got_d   = '0;
      cap_exp_d   = '0;
    end else if (err_inc && !cap_valid_q) begin
      cap_valid_d = 1'b1;
      cap_got_d   = bus.in_data;
      cap_exp_d   = exp_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_valid_q <= 1'b0;
      cap_got_q   <= '0;
      cap_exp_q   <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_got_q   <= cap_got_d;
      cap_exp_q   <= cap_exp_d;
    end
  end

  assign bus.cap_valid = cap_valid_q;
  assign bus.cap_got   = cap_got_q;
  assign bus.cap_exp   = cap_exp_q;
`endif

endmodule
`default_nettype wire
